// File: rtl/traffic_lane.sv
// traffic_lane: one road lane of up to MaxCars cars plus a wrap-buffer car (slot 0).
// Cars are kept as offsets on a modular ring so spacing stays uniform across the wrap.
// Provides a combinational per-pixel sprite lookup and registered player-hit flags.
module traffic_lane #(
   parameter int unsigned TileY     = 0,
   parameter int unsigned MaxCars   = 5,
   parameter int unsigned CarWidth  = 48,
   parameter int unsigned CarHeight = 26,
   parameter int unsigned PlayLeft  = 100,
   parameter int unsigned PlayWidth = 640,
   parameter int unsigned PlayerW   = 32,
   parameter int unsigned PlayerH   = 32,
   localparam int unsigned CW       = $clog2(MaxCars + 1)
) (
   input  logic          frame_clk_i,
   input  logic          reset_i,
   input  logic          spawn_enable_i,
   input  logic          pause_i,
   input  logic          direction_i,
   input  logic [1:0]    car_type_i,
   input  logic [CW-1:0] car_count_i,
   input  logic [2:0]    car_speed_i,
   input  logic [4:0]    p1_hb_offset_i,
   input  logic [4:0]    p2_hb_offset_i,
   input  logic [9:0]    draw_x_i,
   input  logic [9:0]    draw_y_i,
   input  logic [9:0]    p1_x_i,
   input  logic [9:0]    p1_y_i,
   input  logic [9:0]    p2_x_i,
   input  logic [9:0]    p2_y_i,
   output logic          p1_hit_o,
   output logic          p2_hit_o,
   output logic          car_pixel_o,
   output logic [3:0]    tile_o,
   output logic [5:0]    pixel_x_o,
   output logic [4:0]    pixel_y_o,
   output logic          active_o
);

   localparam int unsigned NumSlots  = MaxCars + 1;
   localparam logic [11:0] CarX0     = 12'(PlayLeft - CarWidth);
   localparam logic [11:0] SpawnY    = 12'(10'(16 * TileY - 10));
   localparam logic [11:0] SpawnYEnd = SpawnY + 12'(CarHeight);
   localparam logic [11:0] PlayXEnd  = 12'(PlayLeft + PlayWidth);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StPause} state_e;

   // Car pitch (gap + width) for a given number of road cars; folds to a constant table.
   function automatic logic [10:0] pitch_for(input int unsigned c);
      return 11'((PlayWidth - CarWidth * c) / (c + 1) + CarWidth);
   endfunction

   // Half-open overlap of a player box with one car rectangle.
   function automatic logic box_overlap(input logic [11:0] x_lo, input logic [11:0] x_hi,
                                        input logic [11:0] y_lo, input logic [11:0] y_hi,
                                        input logic [11:0] cx);
      return (x_lo < x_hi) && (x_lo < cx + 12'(CarWidth)) && (cx < x_hi) &&
             (y_lo < SpawnYEnd) && (SpawnY < y_hi);
   endfunction

   state_e          state_q, state_d;
   logic            on_road, moving;
   logic            face_left_q, face_left_d;
   logic [1:0]      type_q, type_d;
   logic [2:0]      speed_q, speed_d;
   logic [CW-1:0]   count_q, count_d, count_clamped;
   logic [10:0]     ring_q, ring_d, pitch_new, ring_new;
   logic [10:0]     off_q [NumSlots];
   logic [10:0]     off_d [NumSlots];
   logic [11:0]     car_x_now [NumSlots];
   logic [11:0]     car_x_next [NumSlots];
   logic            hit1_q, hit1_d, hit2_q, hit2_d;
   logic [11:0]     p1_x_lo, p1_x_hi, p1_y_lo, p1_y_hi;
   logic [11:0]     p2_x_lo, p2_x_hi, p2_y_lo, p2_y_hi;
   logic            pix_found;
   logic [11:0]     pix_rel, dx, dy;

   // FSM state register
   always_ff @(posedge frame_clk_i or posedge reset_i) begin
      if (reset_i) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // FSM next state; spawn overrides everything including pause
   always_comb begin
      state_d = state_q;
      if (spawn_enable_i) begin
         state_d = StLoad;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StIdle;
            StLoad:  state_d = StRun;
            StRun:   if (pause_i) state_d = StPause;
            StPause: if (!pause_i) state_d = StRun;
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      on_road  = (state_q == StRun) || (state_q == StPause);
      moving   = (state_q == StRun) && !pause_i && !spawn_enable_i;
      active_o = on_road;
   end

   // Spawn-time geometry for the requested (clamped) car count
   always_comb begin
      count_clamped = (car_count_i > CW'(MaxCars)) ? CW'(MaxCars) : car_count_i;
      pitch_new     = '0;
      for (int unsigned c = 0; c < NumSlots; c++) begin
         if (count_clamped == CW'(c)) pitch_new = pitch_for(c);
      end
      ring_new = pitch_new * (11'(count_clamped) + 11'd1);
   end

   // Config latch on spawn, ring advance while running
   always_comb begin
      face_left_d = face_left_q;
      type_d      = type_q;
      speed_d     = speed_q;
      count_d     = count_q;
      ring_d      = ring_q;
      off_d       = off_q;
      if (spawn_enable_i) begin
         face_left_d = direction_i;
         type_d      = car_type_i;
         speed_d     = car_speed_i;
         count_d     = count_clamped;
         ring_d      = ring_new;
         for (int unsigned k = 0; k < NumSlots; k++) begin
            off_d[k] = (k <= 32'(count_clamped)) ? 11'(k) * pitch_new : '0;
         end
      end else if (moving) begin
         for (int unsigned k = 0; k < NumSlots; k++) begin
            if (!face_left_q) begin
               off_d[k] = (off_q[k] + 11'(speed_q) >= ring_q) ?
                          off_q[k] + 11'(speed_q) - ring_q : off_q[k] + 11'(speed_q);
            end else begin
               off_d[k] = (off_q[k] < 11'(speed_q)) ?
                          off_q[k] + ring_q - 11'(speed_q) : off_q[k] - 11'(speed_q);
            end
         end
      end
   end

   // Screen X of every slot, current and post-update
   always_comb begin
      for (int unsigned k = 0; k < NumSlots; k++) begin
         car_x_now[k]  = CarX0 + 12'(off_q[k]);
         car_x_next[k] = CarX0 + 12'(off_d[k]);
      end
   end

   assign p1_x_lo = 12'(p1_x_i) + 12'(p1_hb_offset_i);
   assign p1_x_hi = 12'(p1_x_i) + 12'(PlayerW) - 12'(p1_hb_offset_i);
   assign p1_y_lo = 12'(p1_y_i);
   assign p1_y_hi = 12'(p1_y_i) + 12'(PlayerH);
   assign p2_x_lo = 12'(p2_x_i) + 12'(p2_hb_offset_i);
   assign p2_x_hi = 12'(p2_x_i) + 12'(PlayerW) - 12'(p2_hb_offset_i);
   assign p2_y_lo = 12'(p2_y_i);
   assign p2_y_hi = 12'(p2_y_i) + 12'(PlayerH);

   // Player collision against post-update car positions
   always_comb begin
      hit1_d = 1'b0;
      hit2_d = 1'b0;
      if (on_road && !spawn_enable_i && count_q != '0) begin
         for (int unsigned k = 0; k < NumSlots; k++) begin
            if (k <= 32'(count_q)) begin
               hit1_d = hit1_d | box_overlap(p1_x_lo, p1_x_hi, p1_y_lo, p1_y_hi, car_x_next[k]);
               hit2_d = hit2_d | box_overlap(p2_x_lo, p2_x_hi, p2_y_lo, p2_y_hi, car_x_next[k]);
            end
         end
      end
   end

   // Lane config, slot offsets and hit flags
   always_ff @(posedge frame_clk_i or posedge reset_i) begin
      if (reset_i) begin
         face_left_q <= 1'b0;
         type_q      <= '0;
         speed_q     <= '0;
         count_q     <= '0;
         ring_q      <= '0;
         for (int unsigned k = 0; k < NumSlots; k++) off_q[k] <= '0;
         hit1_q      <= 1'b0;
         hit2_q      <= 1'b0;
      end else begin
         face_left_q <= face_left_d;
         type_q      <= type_d;
         speed_q     <= speed_d;
         count_q     <= count_d;
         ring_q      <= ring_d;
         off_q       <= off_d;
         hit1_q      <= hit1_d;
         hit2_q      <= hit2_d;
      end
   end

   assign p1_hit_o = hit1_q;
   assign p2_hit_o = hit2_q;
   assign dx       = 12'(draw_x_i);
   assign dy       = 12'(draw_y_i);

   // Beam pixel lookup; lowest active slot wins where cars overlap
   always_comb begin
      pix_found   = 1'b0;
      pix_rel     = '0;
      car_pixel_o = 1'b0;
      tile_o      = '0;
      pixel_x_o   = '0;
      pixel_y_o   = '0;
      if (on_road && count_q != '0 && dx >= 12'(PlayLeft) && dx < PlayXEnd &&
          dy >= SpawnY && dy < SpawnYEnd) begin
         for (int unsigned k = 0; k < NumSlots; k++) begin
            if (!pix_found && k <= 32'(count_q) && dx >= car_x_now[k] &&
                dx < car_x_now[k] + 12'(CarWidth)) begin
               pix_found = 1'b1;
               pix_rel   = dx - car_x_now[k];
            end
         end
      end
      if (pix_found) begin
         car_pixel_o = 1'b1;
         tile_o      = {1'b0, type_q, face_left_q};
         pixel_x_o   = face_left_q ? 6'(CarWidth - 1) - 6'(pix_rel) : 6'(pix_rel);
         pixel_y_o   = 5'(dy - SpawnY);
      end
   end

endmodule
